cpxdiv_arbiter: RTL and testbench
=================================

Name: cpxdiv_arbiter

Overview:
Round-robin arbiter and sequencer that shares one complex divider (cpxdiv) among N_REQ requesters.
- Accepts requests with a level req/ack handshake and latches the winner's operands.
- Issues a one-cycle run pulse to the divider and tracks the divider's busy flag.
- Returns the quotient on a shared result bus, tagged with the requester index, and pulses that requester's done line.
- Sits between the client blocks and the single cpxdiv instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDW, 2, width of requester index, equal to clog2(N_REQ)

Ports:
clock  in  1  master clock, rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level; hold high with operands stable until ack
req_ops  in  64*N_REQ  per-requester operands; slice i = {ReA,ImA,ReB,ImB} of requester i, 16 bits each, ReA in MSBs
ack  out  N_REQ  one-cycle pulse: operands of requester i latched
done  out  N_REQ  one-cycle pulse: result for requester i valid on res_* this cycle
res_ReY  out  32  real quotient, registered
res_ImY  out  32  imaginary quotient, registered
res_id  out  IDW  requester index owning res_*
arb_busy  out  1  high whenever state is not IDLE
div_run  out  1  run pulse to divider
div_ReA, div_ImA, div_ReB, div_ImB  out  16 each  operands to divider, registered, stable from the issue edge until the next issue
div_busy  in  1  divider busy flag
div_ReY, div_ImY  in  32 each  divider quotients; valid once div_busy falls

Behaviour:
- Reset: all outputs 0; state IDLE; last-grant pointer = N_REQ-1, so requester 0 has highest priority after reset.
- Reset mid-operation aborts the transaction; no done is issued. The divider shares this reset.
- States: IDLE, WAIT_BUSY, WAIT_DONE, RETURN (the last only with the optional feature).
- IDLE, req != 0 at edge E0:
  - Grant the first set req bit searching from (last+1) mod N_REQ upward with wrap.
  - Latch grant index, latch div_* operands from that requester's slice, update last-grant pointer.
  - Set ack[grant]<=1 and div_run<=1; go to WAIT_BUSY.
- IDLE, req == 0: stay in IDLE.
- ack and div_run are high for exactly one cycle, the cycle after E0, then cleared.
- WAIT_BUSY: stay until div_busy==1 is sampled, then go to WAIT_DONE.
  - div_busy is ignored on the edge where div_run is being asserted, because the divider raises busy one cycle after it samples run.
- WAIT_DONE, div_busy==0 sampled at edge Ek:
  - res_ReY<=div_ReY, res_ImY<=div_ImY, res_id<=grant, done[grant]<=1; go to IDLE.
  - done is high for one cycle, so it is visible in the cycle after Ek.
- res_* hold their value until the next done.
- Back-to-back: a request pending while done is high is arbitrated on the following edge (IDLE for one cycle). Minimum gap between successive run pulses = divider busy length + 3 cycles.
- A requester that keeps req high after ack is treated as a new request at the next arbitration.
- Request changes during a transaction do not affect it; only the granted slice is sampled, at E0.
- A simultaneous reset and req: reset wins.
- The arbiter adds no arithmetic; results pass through bit-exact.

Optional Feature:
Macro: CPXARB_DIVZERO_EN
- With it defined:
  - Adds output res_dz (1 bit, reset 0).
  - At E0, if the winner's ReB==0 and ImB==0, no div_run is issued; ack is pulsed and the state goes to RETURN.
  - At the next edge: res_ReY=0, res_ImY=0, res_dz=1, done[grant] pulses; go to IDLE.
  - Normal completions drive res_dz=0.
  - The pointer updates exactly as for a normal grant.
- Without it: no res_dz port; zero divisors are sent to the divider like any other operands.

Test Plan:
- Bench setup: behavioural divider stub, busy 49 cycles, returns ReY=0x00012345, ImY=0xFFFF8000.
- Single request: req[0]=1, ops {0x0100,0x0200,0x0300,0x0400} -> ack[0] one cycle; div_run one cycle with div_ReB=0x0300; done[0] one cycle after busy falls; res_ReY=0x00012345, res_ImY=0xFFFF8000, res_id=0.
- All four req high together, each dropped on its ack -> grant order 0,1,2,3; exactly one done per requester; run pulses spaced 52 cycles.
- Fairness: after serving 1, raise req0 and req2 together -> 2 granted before 0.
- Stub busy stretched to 60 cycles -> done still exactly one cycle after busy falls; res_* unchanged until then.
- Reset asserted mid WAIT_DONE -> all outputs 0, no done; new req3 afterward is granted after a higher-priority req0 raised together.
- With CPXARB_DIVZERO_EN: req1 with ReB=ImB=0 -> no div_run; done[1] one cycle after ack[1]; res_*=0, res_dz=1.

Source files
------------

// File: rtl/cpxdiv_arbiter_if.sv
// Request/result bus between the client blocks, the arbiter and the shared cpxdiv instance.
// res_dz exists only when CPXARB_DIVZERO_EN is defined.
interface cpxdiv_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
);
   logic [N_REQ-1:0]    req;
   logic [64*N_REQ-1:0] req_ops;
   logic [N_REQ-1:0]    ack;
   logic [N_REQ-1:0]    done;
   logic [31:0]         res_ReY;
   logic [31:0]         res_ImY;
   logic [IDW-1:0]      res_id;
`ifdef CPXARB_DIVZERO_EN
   logic                res_dz;
`endif
   logic                arb_busy;
   logic                div_run;
   logic [15:0]         div_ReA;
   logic [15:0]         div_ImA;
   logic [15:0]         div_ReB;
   logic [15:0]         div_ImB;
   logic                div_busy;
   logic [31:0]         div_ReY;
   logic [31:0]         div_ImY;

   // Arbiter side.
   modport slave (
      input  req, req_ops, div_busy, div_ReY, div_ImY,
      output
`ifdef CPXARB_DIVZERO_EN
             res_dz,
`endif
             ack, done, res_ReY, res_ImY, res_id, arb_busy,
             div_run, div_ReA, div_ImA, div_ReB, div_ImB
   );

   // Client and divider side.
   modport master (
      output req, req_ops, div_busy, div_ReY, div_ImY,
      input
`ifdef CPXARB_DIVZERO_EN
             res_dz,
`endif
             ack, done, res_ReY, res_ImY, res_id, arb_busy,
             div_run, div_ReA, div_ImA, div_ReB, div_ImB
   );
endinterface

// File: rtl/cpxdiv_arbiter.sv
// Round-robin arbiter/sequencer sharing one complex divider among N_REQ requesters.
// Optional CPXARB_DIVZERO_EN: zero divisors are answered locally with res_dz=1.
module cpxdiv_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
) (
   input  logic            clock,
   input  logic            reset,
   cpxdiv_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BUSY,
      WAIT_DONE
`ifdef CPXARB_DIVZERO_EN
      , RETURN
`endif
   } state_t;

   state_t           state, stateNext;
   logic [IDW-1:0]   lastGrant, lastGrantNext;
   logic [IDW-1:0]   grantId, grantIdNext;
   logic [N_REQ-1:0] ackReg, ackNext;
   logic [N_REQ-1:0] doneReg, doneNext;
   logic             runReg, runNext;
   logic [63:0]      opsReg, opsNext;
   logic [31:0]      resReY, resReYNext;
   logic [31:0]      resImY, resImYNext;
   logic [IDW-1:0]   resId, resIdNext;
`ifdef CPXARB_DIVZERO_EN
   logic             resDz, resDzNext;
`endif

   logic             winFound;
   logic [IDW-1:0]   winIdx;
   logic [IDW-1:0]   cand;
   logic [63:0]      winOps;

   // Search starts just after the last grant and wraps, so the last winner is lowest priority.
   always_comb begin
      winFound = 1'b0;
      winIdx   = '0;
      cand     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDW'((int'(lastGrant) + 1 + k) % N_REQ);
         if (!winFound && bus.req[cand]) begin
            winFound = 1'b1;
            winIdx   = cand;
         end
      end
      winOps = bus.req_ops[64*int'(winIdx) +: 64];
   end

   always_comb begin
      // NOTE: every variable gets its hold/idle value first so no path can infer a latch.
      stateNext     = state;
      lastGrantNext = lastGrant;
      grantIdNext   = grantId;
      ackNext       = '0;
      doneNext      = '0;
      runNext       = 1'b0;
      opsNext       = opsReg;
      resReYNext    = resReY;
      resImYNext    = resImY;
      resIdNext     = resId;
`ifdef CPXARB_DIVZERO_EN
      resDzNext     = resDz;
`endif
      case (state)
         IDLE: begin
            if (winFound) begin
               grantIdNext      = winIdx;
               lastGrantNext    = winIdx;
               ackNext[winIdx]  = 1'b1;
`ifdef CPXARB_DIVZERO_EN
               if (winOps[31:0] == 32'd0) begin
                  stateNext = RETURN;
               end else begin
                  opsNext   = winOps;
                  runNext   = 1'b1;
                  stateNext = WAIT_BUSY;
               end
`else
               opsNext   = winOps;
               runNext   = 1'b1;
               stateNext = WAIT_BUSY;
`endif
            end
         end
         // The divider raises busy a cycle after it samples run, so this state absorbs that gap.
         WAIT_BUSY: begin
            if (bus.div_busy) stateNext = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!bus.div_busy) begin
               resReYNext        = bus.div_ReY;
               resImYNext        = bus.div_ImY;
               resIdNext         = grantId;
               doneNext[grantId] = 1'b1;
`ifdef CPXARB_DIVZERO_EN
               resDzNext         = 1'b0;
`endif
               stateNext         = IDLE;
            end
         end
`ifdef CPXARB_DIVZERO_EN
         RETURN: begin
            resReYNext        = '0;
            resImYNext        = '0;
            resIdNext         = grantId;
            resDzNext         = 1'b1;
            doneNext[grantId] = 1'b1;
            stateNext         = IDLE;
         end
`endif
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         lastGrant <= IDW'(N_REQ - 1);
         grantId   <= '0;
         ackReg    <= '0;
         doneReg   <= '0;
         runReg    <= 1'b0;
         opsReg    <= '0;
         resReY    <= '0;
         resImY    <= '0;
         resId     <= '0;
`ifdef CPXARB_DIVZERO_EN
         resDz     <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge values.
         state     <= stateNext;
         lastGrant <= lastGrantNext;
         grantId   <= grantIdNext;
         ackReg    <= ackNext;
         doneReg   <= doneNext;
         runReg    <= runNext;
         opsReg    <= opsNext;
         resReY    <= resReYNext;
         resImY    <= resImYNext;
         resId     <= resIdNext;
`ifdef CPXARB_DIVZERO_EN
         resDz     <= resDzNext;
`endif
      end
   end

   assign bus.ack      = ackReg;
   assign bus.done     = doneReg;
   assign bus.div_run  = runReg;
   assign bus.div_ReA  = opsReg[63:48];
   assign bus.div_ImA  = opsReg[47:32];
   assign bus.div_ReB  = opsReg[31:16];
   assign bus.div_ImB  = opsReg[15:0];
   assign bus.res_ReY  = resReY;
   assign bus.res_ImY  = resImY;
   assign bus.res_id   = resId;
   assign bus.arb_busy = (state != IDLE);
`ifdef CPXARB_DIVZERO_EN
   assign bus.res_dz   = resDz;
`endif

endmodule

// File: tb/tb_cpxdiv_arbiter.sv
// Self-checking bench for cpxdiv_arbiter with a behavioural divider stub and a result scoreboard.
// Exercises the CPXARB_DIVZERO_EN path when that macro is defined.
module tb_cpxdiv_arbiter;
   localparam int N_REQ = 4;
   localparam int IDW   = 2;
   localparam logic [31:0] DEF_REY = 32'h0001_2345;
   localparam logic [31:0] DEF_IMY = 32'hFFFF_8000;

   typedef struct {
      int          id;
      logic [31:0] reY;
      logic [31:0] imY;
      logic        dz;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   exp_t        sbQ[$];
   int          nCompared = 0;
   int          nMismatch = 0;
   int          busyLen   = 49;
   logic [31:0] stubReY   = DEF_REY;
   logic [31:0] stubImY   = DEF_IMY;
   logic        stubBusy  = 1'b0;
   int          stubCnt   = 0;
   int          cycleCnt  = 0;

   cpxdiv_arbiter_if #(.N_REQ(N_REQ), .IDW(IDW)) bus ();

   cpxdiv_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycleCnt <= cycleCnt + 1;

   // Divider stub: busy rises the cycle after run and stays high busyLen cycles.
   always @(posedge clock) begin
      if (reset) begin
         stubBusy <= 1'b0;
         stubCnt  <= 0;
      end else if (bus.div_run) begin
         stubBusy <= 1'b1;
         stubCnt  <= busyLen;
      end else if (stubBusy) begin
         if (stubCnt == 1) stubBusy <= 1'b0;
         stubCnt <= stubCnt - 1;
      end
   end

   assign bus.div_busy = stubBusy;
   assign bus.div_ReY  = stubReY;
   assign bus.div_ImY  = stubImY;

   function automatic logic [63:0] mk_ops(input int i);
      return {16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 16'h4000 + 16'(i)};
   endfunction

   function automatic logic [139:0] out_vec();
      return {bus.ack, bus.done, bus.res_ReY, bus.res_ImY, bus.res_id, bus.arb_busy,
              bus.div_run, bus.div_ReA, bus.div_ImA, bus.div_ReB, bus.div_ImB};
   endfunction

   function automatic logic dz_bit();
`ifdef CPXARB_DIVZERO_EN
      return bus.res_dz;
`else
      return 1'b0;
`endif
   endfunction

   task automatic push_exp(input int id, input logic [31:0] reY, input logic [31:0] imY, input logic dz);
      exp_t e;
      e.id  = id;
      e.reY = reY;
      e.imY = imY;
      e.dz  = dz;
      sbQ.push_back(e);
   endtask

   task automatic wait_ack(input int budget, output logic [N_REQ-1:0] seen);
      seen = '0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clock);
         if (bus.ack != '0) begin
            seen = bus.ack;
            return;
         end
      end
   endtask

   task automatic wait_drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clock);
         if (sbQ.size() == 0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Scoreboard: every done pulse pops and checks one expected result.
   task automatic monitor_loop();
      exp_t e;
      logic [N_REQ-1:0] expDone;
      logic dzBad;
      forever begin
         @(negedge clock);
         if (bus.done !== '0) begin
            nCompared++;
            if (sbQ.size() == 0) begin
               nMismatch++;
               $display("FAIL sb_unexpected_done: done=%b with nothing outstanding", bus.done);
            end else begin
               e = sbQ.pop_front();
               expDone = '0;
               expDone[e.id] = 1'b1;
               dzBad = (dz_bit() !== e.dz);
               if (bus.done !== expDone || bus.res_id !== IDW'(e.id) || bus.res_ReY !== e.reY ||
                   bus.res_ImY !== e.imY || dzBad) begin
                  nMismatch++;
                  $display("FAIL sb_result: got done=%b id=%0d ReY=%h ImY=%h dz=%b, want done=%b id=%0d ReY=%h ImY=%h dz=%b",
                           bus.done, bus.res_id, bus.res_ReY, bus.res_ImY, dz_bit(),
                           expDone, e.id, e.reY, e.imY, e.dz);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req = 4'b0001;
      bus.req_ops[63:0] = mk_ops(0);
      repeat (3) @(negedge clock);
      nCompared++;
      if (bus.ack !== '0 || bus.arb_busy !== 1'b0 || bus.div_run !== 1'b0) begin
         nMismatch++;
         $display("FAIL reset_beats_req: ack=%b busy=%b run=%b, want all 0", bus.ack, bus.arb_busy, bus.div_run);
      end
      bus.req = '0;
      @(negedge clock);
      nCompared++;
      if (out_vec() !== '0 || dz_bit() !== 1'b0) begin
         nMismatch++;
         $display("FAIL reset_outputs: outputs=%h dz=%b, want 0", out_vec(), dz_bit());
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      nCompared++;
      if (bus.arb_busy !== 1'b0 || bus.ack !== '0) begin
         nMismatch++;
         $display("FAIL idle_no_req: busy=%b ack=%b, want 0", bus.arb_busy, bus.ack);
      end
   endtask

   task automatic test_all_four();
      logic [N_REQ-1:0] a;
      logic [N_REQ-1:0] want;
      int prevCyc;
      bit ok;
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_ops[64*i +: 64] = mk_ops(i);
         push_exp(i, stubReY, stubImY, 1'b0);
      end
      bus.req = '1;
      prevCyc = -1;
      for (int g = 0; g < N_REQ; g++) begin
         wait_ack(80, a);
         want = '0;
         want[g] = 1'b1;
         nCompared++;
         if (a !== want || bus.div_run !== 1'b1 ||
             {bus.div_ReA, bus.div_ImA, bus.div_ReB, bus.div_ImB} !== mk_ops(g)) begin
            nMismatch++;
            $display("FAIL all4_issue: ack=%b run=%b ops=%h, want ack=%b run=1 ops=%h", a, bus.div_run,
                     {bus.div_ReA, bus.div_ImA, bus.div_ReB, bus.div_ImB}, want, mk_ops(g));
         end
         if (prevCyc >= 0) begin
            nCompared++;
            if (cycleCnt - prevCyc != busyLen + 3) begin
               nMismatch++;
               $display("FAIL all4_spacing: gap=%0d, want %0d", cycleCnt - prevCyc, busyLen + 3);
            end
         end
         prevCyc = cycleCnt;
         bus.req[g] = 1'b0;
      end
      wait_drain(300, ok);
      nCompared++;
      if (!ok) begin
         nMismatch++;
         $display("FAIL all4_drain: %0d results outstanding, want 0", sbQ.size());
      end
   endtask

   task automatic test_single();
      logic [N_REQ-1:0] a;
      int lat;
      bus.req_ops[63:0] = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
      push_exp(0, DEF_REY, DEF_IMY, 1'b0);
      bus.req[0] = 1'b1;
      wait_ack(10, a);
      nCompared++;
      if (a !== 4'b0001 || bus.div_run !== 1'b1 || bus.div_ReA !== 16'h0100 || bus.div_ImA !== 16'h0200 ||
          bus.div_ReB !== 16'h0300 || bus.div_ImB !== 16'h0400) begin
         nMismatch++;
         $display("FAIL single_issue: ack=%b run=%b ReA=%h ImA=%h ReB=%h ImB=%h, want 0001 1 0100 0200 0300 0400",
                  a, bus.div_run, bus.div_ReA, bus.div_ImA, bus.div_ReB, bus.div_ImB);
      end
      bus.req[0] = 1'b0;
      bus.req_ops[63:0] = '1;
      @(negedge clock);
      nCompared++;
      if (bus.ack !== '0 || bus.div_run !== 1'b0 || bus.div_ReB !== 16'h0300 ||
          bus.div_ReA !== 16'h0100 || bus.arb_busy !== 1'b1) begin
         nMismatch++;
         $display("FAIL single_pulse: ack=%b run=%b ReA=%h ReB=%h busy=%b, want 0000 0 0100 0300 1",
                  bus.ack, bus.div_run, bus.div_ReA, bus.div_ReB, bus.arb_busy);
      end
      lat = 2;
      for (; lat < 200; lat++) begin
         @(negedge clock);
         if (bus.done != '0) break;
      end
      nCompared++;
      if (lat != busyLen + 2 || bus.arb_busy !== 1'b0) begin
         nMismatch++;
         $display("FAIL single_latency: ack-to-done=%0d busy=%b, want %0d busy=0", lat, bus.arb_busy, busyLen + 2);
      end
      @(negedge clock);
      nCompared++;
      if (bus.done !== '0 || bus.res_ReY !== DEF_REY || bus.res_ImY !== DEF_IMY || bus.res_id !== 2'd0) begin
         nMismatch++;
         $display("FAIL single_hold: done=%b ReY=%h ImY=%h id=%0d, want 0000 %h %h 0",
                  bus.done, bus.res_ReY, bus.res_ImY, bus.res_id, DEF_REY, DEF_IMY);
      end
   endtask

   task automatic test_fairness();
      logic [N_REQ-1:0] a;
      bit ok;
      bus.req_ops[64*1 +: 64] = mk_ops(1);
      push_exp(1, DEF_REY, DEF_IMY, 1'b0);
      bus.req[1] = 1'b1;
      wait_ack(10, a);
      nCompared++;
      if (a !== 4'b0010) begin
         nMismatch++;
         $display("FAIL fair_serve1: ack=%b, want 0010", a);
      end
      bus.req[1] = 1'b0;
      wait_drain(100, ok);
      bus.req_ops[64*0 +: 64] = mk_ops(0);
      bus.req_ops[64*2 +: 64] = mk_ops(2);
      push_exp(2, DEF_REY, DEF_IMY, 1'b0);
      push_exp(0, DEF_REY, DEF_IMY, 1'b0);
      bus.req = 4'b0101;
      wait_ack(10, a);
      nCompared++;
      if (a !== 4'b0100) begin
         nMismatch++;
         $display("FAIL fair_first: ack=%b, want 0100", a);
      end
      bus.req[2] = 1'b0;
      wait_ack(80, a);
      nCompared++;
      if (a !== 4'b0001) begin
         nMismatch++;
         $display("FAIL fair_second: ack=%b, want 0001", a);
      end
      bus.req[0] = 1'b0;
      wait_drain(100, ok);
      nCompared++;
      if (!ok) begin
         nMismatch++;
         $display("FAIL fair_drain: %0d results outstanding, want 0", sbQ.size());
      end
   endtask

   task automatic test_stretch();
      logic [N_REQ-1:0] a;
      int lat;
      bit holdBad;
      busyLen = 60;
      stubReY = 32'hAAAA_5555;
      stubImY = 32'h0000_7FFF;
      bus.req_ops[64*3 +: 64] = mk_ops(3);
      push_exp(3, 32'hAAAA_5555, 32'h0000_7FFF, 1'b0);
      bus.req[3] = 1'b1;
      wait_ack(10, a);
      nCompared++;
      if (a !== 4'b1000) begin
         nMismatch++;
         $display("FAIL stretch_ack: ack=%b, want 1000", a);
      end
      bus.req[3] = 1'b0;
      holdBad = 1'b0;
      lat = 1;
      for (; lat < 200; lat++) begin
         @(negedge clock);
         if (bus.done != '0) break;
         if (bus.res_ReY !== DEF_REY || bus.res_ImY !== DEF_IMY || bus.res_id !== 2'd0) holdBad = 1'b1;
      end
      nCompared++;
      if (lat != 62 || holdBad) begin
         nMismatch++;
         $display("FAIL stretch_timing: ack-to-done=%0d res_changed_early=%b, want 62 0", lat, holdBad);
      end
      @(negedge clock);
      busyLen = 49;
      stubReY = DEF_REY;
      stubImY = DEF_IMY;
   endtask

   task automatic test_reset_mid();
      logic [N_REQ-1:0] a;
      int doneCnt;
      bit ok;
      bus.req_ops[64*2 +: 64] = mk_ops(2);
      bus.req[2] = 1'b1;
      wait_ack(10, a);
      bus.req[2] = 1'b0;
      repeat (10) @(negedge clock);
      nCompared++;
      if (a !== 4'b0100 || bus.arb_busy !== 1'b1) begin
         nMismatch++;
         $display("FAIL midrst_setup: ack=%b busy=%b, want 0100 1", a, bus.arb_busy);
      end
      reset = 1'b1;
      repeat (2) @(negedge clock);
      nCompared++;
      if (out_vec() !== '0 || dz_bit() !== 1'b0) begin
         nMismatch++;
         $display("FAIL midrst_outputs: outputs=%h dz=%b, want 0", out_vec(), dz_bit());
      end
      reset = 1'b0;
      doneCnt = 0;
      repeat (70) begin
         @(negedge clock);
         if (bus.done != '0) doneCnt++;
      end
      nCompared++;
      if (doneCnt != 0 || bus.arb_busy !== 1'b0) begin
         nMismatch++;
         $display("FAIL midrst_no_done: done pulses=%0d busy=%b, want 0 0", doneCnt, bus.arb_busy);
      end
      bus.req_ops[64*0 +: 64] = mk_ops(0);
      bus.req_ops[64*3 +: 64] = mk_ops(3);
      push_exp(0, DEF_REY, DEF_IMY, 1'b0);
      push_exp(3, DEF_REY, DEF_IMY, 1'b0);
      bus.req = 4'b1001;
      wait_ack(10, a);
      nCompared++;
      if (a !== 4'b0001) begin
         nMismatch++;
         $display("FAIL midrst_first: ack=%b, want 0001", a);
      end
      bus.req[0] = 1'b0;
      wait_ack(80, a);
      nCompared++;
      if (a !== 4'b1000) begin
         nMismatch++;
         $display("FAIL midrst_second: ack=%b, want 1000", a);
      end
      bus.req[3] = 1'b0;
      wait_drain(100, ok);
      nCompared++;
      if (!ok) begin
         nMismatch++;
         $display("FAIL midrst_drain: %0d results outstanding, want 0", sbQ.size());
      end
   endtask

   task automatic test_zero_divisor();
      logic [N_REQ-1:0] a;
      bit ok;
      bus.req_ops[64*1 +: 64] = {16'h0005, 16'h0006, 16'h0000, 16'h0000};
`ifdef CPXARB_DIVZERO_EN
      push_exp(1, 32'd0, 32'd0, 1'b1);
      bus.req[1] = 1'b1;
      wait_ack(10, a);
      nCompared++;
      if (a !== 4'b0010 || bus.div_run !== 1'b0) begin
         nMismatch++;
         $display("FAIL dz_ack: ack=%b run=%b, want 0010 0", a, bus.div_run);
      end
      bus.req[1] = 1'b0;
      @(negedge clock);
      nCompared++;
      if (bus.done !== 4'b0010 || bus.div_run !== 1'b0) begin
         nMismatch++;
         $display("FAIL dz_done: done=%b run=%b, want 0010 0", bus.done, bus.div_run);
      end
      bus.req_ops[64*2 +: 64] = mk_ops(2);
      push_exp(2, DEF_REY, DEF_IMY, 1'b0);
      bus.req[2] = 1'b1;
      wait_ack(10, a);
      bus.req[2] = 1'b0;
      nCompared++;
      if (a !== 4'b0100 || bus.div_run !== 1'b1) begin
         nMismatch++;
         $display("FAIL dz_followup: ack=%b run=%b, want 0100 1", a, bus.div_run);
      end
`else
      push_exp(1, DEF_REY, DEF_IMY, 1'b0);
      bus.req[1] = 1'b1;
      wait_ack(10, a);
      nCompared++;
      if (a !== 4'b0010 || bus.div_run !== 1'b1 || bus.div_ReB !== 16'h0000 || bus.div_ImB !== 16'h0000 ||
          bus.div_ReA !== 16'h0005) begin
         nMismatch++;
         $display("FAIL zdiv_issue: ack=%b run=%b ReA=%h ReB=%h ImB=%h, want 0010 1 0005 0000 0000",
                  a, bus.div_run, bus.div_ReA, bus.div_ReB, bus.div_ImB);
      end
      bus.req[1] = 1'b0;
`endif
      wait_drain(100, ok);
      nCompared++;
      if (!ok) begin
         nMismatch++;
         $display("FAIL zdiv_drain: %0d results outstanding, want 0", sbQ.size());
      end
   endtask

   initial begin
      bus.req     = '0;
      bus.req_ops = '0;
      reset       = 1'b1;
      fork
         monitor_loop();
      join_none
      test_reset();
      test_all_four();
      test_single();
      test_fairness();
      test_stretch();
      test_reset_mid();
      test_zero_divisor();
      repeat (5) @(negedge clock);
      nCompared++;
      if (sbQ.size() != 0) begin
         nMismatch++;
         $display("FAIL leftover: %0d results never returned, want 0", sbQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
